gen_xifo_v2: RTL and testbench

Parametrised single-clock queue, successor to the fixed FIFO/LIFO buffer, for instruction, load/store and writeback staging in the in-order single-issue core. Mode (FIFO or LIFO) is chosen by parameter. Adds:
- arbitrary (non-power-of-two) depth
- occupancy count and almost-full/almost-empty flags
- synchronous flush for pipeline squash
- sticky overflow/underflow error flags
- registered read port with an explicit valid strobe

---
 rtl/xifo_pkg.sv | 15 +
 rtl/xifo_ram.sv | 38 +++
 rtl/gen_xifo_v2.sv | 147 ++++++++++++++
 tb/tb_gen_xifo_v2.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/xifo_pkg.sv
// Shared types and helpers for the gen_xifo_v2 staging queue.
// Mode selection enum and the wrapping pointer increment used for arbitrary depths.
package xifo_pkg;

    typedef enum logic {
        XIFO_FIFO = 1'b0,
        XIFO_LIFO = 1'b1
    } xifo_mode_e;

    // Explicit compare-and-wrap so depths that are not powers of two work.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/xifo_ram.sv
// 1-write/1-read storage array with a synchronous write and a registered, enabled read.
// Read-during-write to the same address returns the old contents.
module xifo_ram #(
    parameter int unsigned DWidth = 32,
    parameter int unsigned Depth  = 16,
    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [AddrW-1:0]  i_wr_addr,
    input  logic [DWidth-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AddrW-1:0]  i_rd_addr,
    output logic [DWidth-1:0] o_rd_data
);

    logic [DWidth-1:0] r_mem [Depth];
    logic [DWidth-1:0] r_rd_data;

    // NOTE: the array has no reset; clearing every word would turn it into flops and nothing reads it before a write.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/gen_xifo_v2.sv
// Parametrised FIFO/LIFO staging queue: pointer and occupancy control, registered status
// and sticky error flags around a single xifo_ram instance.
module gen_xifo_v2
    import xifo_pkg::*;
#(
    parameter int unsigned DWidth     = 32,
    parameter int unsigned QueueDepth = 16,
    parameter xifo_mode_e  Mode       = XIFO_FIFO,
    parameter int unsigned AfMargin   = 2,
    parameter int unsigned AeMargin   = 2,
    localparam int unsigned CntW      = $clog2(QueueDepth + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DWidth-1:0] data_in,
    input  logic              pop,
    output logic [DWidth-1:0] data_out,
    output logic              out_valid,
    output logic [CntW-1:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned PtrW    = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
    localparam int          AfLevel = int'(QueueDepth) - int'(AfMargin);
    localparam int          AeLevel = int'(AeMargin);

    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic            r_full;
    logic            r_empty;
    logic            r_almost_full;
    logic            r_almost_empty;
    logic            r_overflow;
    logic            r_underflow;
    logic            r_out_valid;

    logic            w_pop_ok;
    logic            w_push_ok;
    logic [CntW-1:0] w_next_count;
    logic [PtrW-1:0] w_wr_addr;
    logic [PtrW-1:0] w_rd_addr;
    logic            w_ram_wr_en;
    logic            w_ram_rd_en;

    // A full queue still takes a push when a pop frees a slot in the same cycle.
    assign w_pop_ok  = pop && !r_empty;
    assign w_push_ok = push && (!r_full || w_pop_ok);

    // NOTE: combinational logic uses blocking '=' with a default first so no latch is inferred.
    always_comb begin
        w_next_count = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_next_count = r_count + CntW'(1);
            2'b01:   w_next_count = r_count - CntW'(1);
            default: w_next_count = r_count;
        endcase
    end

    // LIFO addresses come from the occupancy; push+pop overwrites the slot being read out.
    always_comb begin
        w_wr_addr = r_wr_ptr;
        w_rd_addr = r_rd_ptr;
        if (Mode == XIFO_LIFO) begin
            w_rd_addr = PtrW'(r_count - CntW'(1));
            w_wr_addr = w_pop_ok ? PtrW'(r_count - CntW'(1)) : PtrW'(r_count);
        end
    end

    assign w_ram_wr_en = w_push_ok && !flush && !rst;
    assign w_ram_rd_en = w_pop_ok && !flush;

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_out_valid    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_out_valid    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= PtrW'(ptr_inc(32'(r_wr_ptr), QueueDepth));
            end
            if (w_pop_ok) begin
                r_rd_ptr <= PtrW'(ptr_inc(32'(r_rd_ptr), QueueDepth));
            end
            r_count        <= w_next_count;
            r_full         <= (w_next_count == CntW'(QueueDepth));
            r_empty        <= (w_next_count == '0);
            r_almost_full  <= (int'(w_next_count) >= AfLevel);
            r_almost_empty <= (int'(w_next_count) <= AeLevel);
            r_out_valid    <= w_pop_ok;
            if (push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            if (pop && !w_pop_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    xifo_ram #(
        .DWidth (DWidth),
        .Depth  (QueueDepth)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_ram_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (data_in),
        .i_rd_en   (w_ram_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (data_out)
    );

    assign out_valid    = r_out_valid;
    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_gen_xifo_v2.sv
// Drives three queue configurations (FIFO depth 5, LIFO depth 6, FIFO depth 16) with shared
// stimulus and checks each against a queue-based reference model.
module tb_gen_xifo_v2;
    import xifo_pkg::*;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       push;
    logic       pop;
    logic [7:0] din;

    logic [7:0] dout_a, dout_b, dout_c;
    logic       ov_a, ov_b, ov_c;
    logic [2:0] cnt_a;
    logic [2:0] cnt_b;
    logic [4:0] cnt_c;
    logic       full_a, full_b, full_c;
    logic       empty_a, empty_b, empty_c;
    logic       af_a, af_b, af_c;
    logic       ae_a, ae_b, ae_c;
    logic       ovf_a, ovf_b, ovf_c;
    logic       udf_a, udf_b, udf_c;

    int n_checks;
    int n_err;

    // Reference model: one data queue per instance plus the observable registers.
    logic [7:0] mq [3][$];
    int         dep [3];
    bit         is_lifo [3];
    logic [7:0] m_dout [3];
    bit         m_ov [3];
    bit         m_of [3];
    bit         m_uf [3];

    gen_xifo_v2 #(.DWidth(8), .QueueDepth(5), .Mode(XIFO_FIFO), .AfMargin(2), .AeMargin(2)) u_fifo5 (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(din), .pop(pop),
        .data_out(dout_a), .out_valid(ov_a), .count(cnt_a), .full(full_a), .empty(empty_a),
        .almost_full(af_a), .almost_empty(ae_a), .overflow(ovf_a), .underflow(udf_a));

    gen_xifo_v2 #(.DWidth(8), .QueueDepth(6), .Mode(XIFO_LIFO), .AfMargin(2), .AeMargin(2)) u_lifo6 (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(din), .pop(pop),
        .data_out(dout_b), .out_valid(ov_b), .count(cnt_b), .full(full_b), .empty(empty_b),
        .almost_full(af_b), .almost_empty(ae_b), .overflow(ovf_b), .underflow(udf_b));

    gen_xifo_v2 #(.DWidth(8), .QueueDepth(16), .Mode(XIFO_FIFO), .AfMargin(2), .AeMargin(2)) u_fifo16 (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(din), .pop(pop),
        .data_out(dout_c), .out_valid(ov_c), .count(cnt_c), .full(full_c), .empty(empty_c),
        .almost_full(af_c), .almost_empty(ae_c), .overflow(ovf_c), .underflow(udf_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input int k, input bit r, input bit f, input bit pu, input bit po,
                                input logic [7:0] d);
        int n;
        bit pop_ok;
        bit push_ok;
        n = mq[k].size();
        if (r) begin
            mq[k].delete();
            m_dout[k] = 8'h00;
            m_ov[k]   = 1'b0;
            m_of[k]   = 1'b0;
            m_uf[k]   = 1'b0;
        end else if (f) begin
            mq[k].delete();
            m_ov[k] = 1'b0;
        end else begin
            pop_ok  = po && (n > 0);
            push_ok = pu && ((n < dep[k]) || pop_ok);
            if (pu && !push_ok) m_of[k] = 1'b1;
            if (po && !pop_ok)  m_uf[k] = 1'b1;
            if (pop_ok) m_dout[k] = is_lifo[k] ? mq[k].pop_back() : mq[k].pop_front();
            if (push_ok) mq[k].push_back(d);
            m_ov[k] = pop_ok;
        end
    endtask

    task automatic check_dut(input int k);
        logic [7:0] o_d;
        logic [4:0] o_c;
        logic       o_v, o_f, o_e, o_af, o_ae, o_of, o_uf;
        string      nm;
        int         n;
        case (k)
            0: begin nm = "fifo5"; o_d = dout_a; o_c = 5'(cnt_a); o_v = ov_a; o_f = full_a; o_e = empty_a;
                     o_af = af_a; o_ae = ae_a; o_of = ovf_a; o_uf = udf_a; end
            1: begin nm = "lifo6"; o_d = dout_b; o_c = 5'(cnt_b); o_v = ov_b; o_f = full_b; o_e = empty_b;
                     o_af = af_b; o_ae = ae_b; o_of = ovf_b; o_uf = udf_b; end
            default: begin nm = "fifo16"; o_d = dout_c; o_c = cnt_c; o_v = ov_c; o_f = full_c; o_e = empty_c;
                     o_af = af_c; o_ae = ae_c; o_of = ovf_c; o_uf = udf_c; end
        endcase
        n = mq[k].size();
        chk({nm, "_count"},        32'(o_c),  32'(n));
        chk({nm, "_full"},         32'(o_f),  32'(n == dep[k]));
        chk({nm, "_empty"},        32'(o_e),  32'(n == 0));
        chk({nm, "_almost_full"},  32'(o_af), 32'(n >= dep[k] - 2));
        chk({nm, "_almost_empty"}, 32'(o_ae), 32'(n <= 2));
        chk({nm, "_out_valid"},    32'(o_v),  32'(m_ov[k]));
        chk({nm, "_data_out"},     32'(o_d),  32'(m_dout[k]));
        chk({nm, "_overflow"},     32'(o_of), 32'(m_of[k]));
        chk({nm, "_underflow"},    32'(o_uf), 32'(m_uf[k]));
    endtask

    // One clock of stimulus: apply inputs, clock, sample 1 time unit later, check all instances.
    task automatic step(input bit r, input bit f, input bit pu, input bit po, input logic [7:0] d);
        rst = r; flush = f; push = pu; pop = po; din = d;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) model_update(k, r, f, pu, po, d);
        rst = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0;
        for (int k = 0; k < 3; k++) check_dut(k);
    endtask

    initial begin
        logic [7:0] exp_byte;
        n_checks = 0;
        n_err    = 0;
        dep      = '{5, 6, 16};
        is_lifo  = '{1'b0, 1'b1, 1'b0};
        rst = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00;

        // Reset state
        step(1, 0, 0, 0, 8'h00);
        chk("rst_empty",        32'(empty_a), 32'd1);
        chk("rst_almost_empty", 32'(ae_a),    32'd1);
        chk("rst_data_out",     32'(dout_a),  32'd0);

        // FIFO order and wrap, three laps through the depth-5 queue
        for (int lap = 0; lap < 3; lap++) begin
            for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'(8'h11 * (i + 1)));
            chk("fifo5_filled_full",  32'(full_a), 32'd1);
            chk("fifo5_filled_count", 32'(cnt_a),  32'd5);
            for (int i = 0; i < 5; i++) begin
                step(0, 0, 0, 1, 8'h00);
                exp_byte = 8'(8'h11 * (i + 1));
                chk("fifo5_order_data",  32'(dout_a), 32'(exp_byte));
                chk("fifo5_order_valid", 32'(ov_a),   32'd1);
            end
            step(0, 0, 0, 0, 8'h00);
            chk("fifo5_valid_pulse", 32'(ov_a), 32'd0);
        end

        // LIFO order and same-cycle replace
        step(0, 0, 1, 0, 8'hA1);
        step(0, 0, 1, 0, 8'hB2);
        step(0, 0, 1, 0, 8'hC3);
        step(0, 0, 0, 1, 8'h00); chk("lifo_pop_c", 32'(dout_b), 32'hC3);
        step(0, 0, 0, 1, 8'h00); chk("lifo_pop_b", 32'(dout_b), 32'hB2);
        step(0, 0, 0, 1, 8'h00); chk("lifo_pop_a", 32'(dout_b), 32'hA1);
        step(0, 0, 1, 0, 8'hA1);
        step(0, 0, 1, 0, 8'hB2);
        step(0, 0, 1, 1, 8'hD4);
        chk("lifo_replace_data",  32'(dout_b), 32'hB2);
        chk("lifo_replace_count", 32'(cnt_b),  32'd2);
        step(0, 0, 0, 1, 8'h00); chk("lifo_pop_d", 32'(dout_b), 32'hD4);
        step(0, 0, 0, 1, 8'h00);

        // Full with simultaneous push+pop, then a rejected push
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'(8'h61 + i));
        step(0, 0, 1, 1, 8'h66);
        chk("full_pp_data",     32'(dout_a), 32'h61);
        chk("full_pp_count",    32'(cnt_a),  32'd5);
        chk("full_pp_overflow", 32'(ovf_a),  32'd0);
        step(0, 0, 1, 0, 8'h77);
        chk("full_push_overflow", 32'(ovf_a), 32'd1);
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 1, 0, 8'h78);
        step(0, 0, 1, 1, 8'h79);
        chk("overflow_sticky", 32'(ovf_a), 32'd1);

        // Empty: pop alone, then push+pop
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'h00);
        chk("empty_pop_underflow", 32'(udf_a), 32'd1);
        chk("empty_pop_valid",     32'(ov_a),  32'd0);
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 1, 8'h5A);
        chk("empty_pp_count",     32'(cnt_a), 32'd1);
        chk("empty_pp_underflow", 32'(udf_a), 32'd1);
        chk("empty_pp_valid",     32'(ov_a),  32'd0);

        // Flush keeps sticky flags; reset clears everything
        step(0, 0, 1, 0, 8'h21);
        step(0, 0, 1, 0, 8'h22);
        step(0, 1, 1, 0, 8'h23);
        chk("flush_count",     32'(cnt_a), 32'd0);
        chk("flush_empty",     32'(empty_a), 32'd1);
        chk("flush_underflow", 32'(udf_a), 32'd1);
        step(0, 0, 1, 1, 8'h24);
        step(0, 1, 0, 1, 8'h00);
        chk("flush_pop_valid", 32'(ov_a), 32'd0);
        step(1, 0, 0, 0, 8'h00);
        chk("rst2_data_out",  32'(dout_b), 32'd0);
        chk("rst2_underflow", 32'(udf_a),  32'd0);
        chk("rst2_count",     32'(cnt_c),  32'd0);

        // Thresholds on the depth-16 queue
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 1, 0, 8'(i));
            chk($sformatf("af_at_%0d", i), 32'(af_c), 32'(i >= 14));
        end
        for (int i = 15; i >= 0; i--) begin
            step(0, 0, 0, 1, 8'h00);
            chk($sformatf("ae_at_%0d", i), 32'(ae_c), 32'(i <= 2));
        end

        // Randomised traffic against the reference model
        for (int t = 0; t < 1000; t++) begin
            int bias;
            bias = (t < 500) ? 65 : 35;
            step($urandom_range(0, 249) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 99) < bias,
                 $urandom_range(0, 99) < (100 - bias),
                 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
